// File: rtl/aco_pkg.sv
// Shared constants and types for the aco acoustic front-end blocks.
package aco_pkg;

    localparam int SAMPLE_BW = 16;
    localparam int FRAME_LEN = 256;
    localparam int HOP_LEN   = 128;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READ
    } framer_state_t;

endpackage

// File: rtl/fft_framer_if.sv
// Stream bundle between the decimator, the framer and the FFT wrapper.
interface fft_framer_if #(
    parameter int SAMPLE_BW = aco_pkg::SAMPLE_BW
) ();

    logic                        en_i;
    logic signed [SAMPLE_BW-1:0] data_i;
    logic                        valid_i;
    logic                        ready_i;
    logic signed [SAMPLE_BW-1:0] data_o;
    logic                        valid_o;
    logic                        last_o;
    logic                        overrun_o;

    modport master (
        output en_i, data_i, valid_i, ready_i,
        input  data_o, valid_o, last_o, overrun_o
    );

    modport slave (
        input  en_i, data_i, valid_i, ready_i,
        output data_o, valid_o, last_o, overrun_o
    );

endinterface

// File: rtl/fft_framer_ram.sv
// Simple dual-port register array with registered, read-first read port.
module fft_framer_ram #(
    parameter int WIDTH = aco_pkg::SAMPLE_BW,
    parameter int DEPTH = aco_pkg::FRAME_LEN,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             re,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Both updates are non-blocking, so a same-address write lands after the read samples old data.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_framer.sv
// Circular sample buffer that replays overlapping FRAME_LEN bursts, one per HOP_LEN new samples.
module fft_framer #(
    parameter int SAMPLE_BW = aco_pkg::SAMPLE_BW,
    parameter int FRAME_LEN = aco_pkg::FRAME_LEN,
    parameter int HOP_LEN   = aco_pkg::HOP_LEN
) (
    input  logic         clk_i,
    input  logic         rst_i,
    fft_framer_if.slave  bus
);

    import aco_pkg::*;

    localparam int PTR_BW = $clog2(FRAME_LEN);
    localparam int HOP_BW = (HOP_LEN > 1) ? $clog2(HOP_LEN) : 1;

    localparam logic [PTR_BW-1:0] PTR_ONE   = 1;
    localparam logic [PTR_BW-1:0] RD_LAST   = PTR_BW'(FRAME_LEN - 1);
    localparam logic [PTR_BW:0]   FILL_ONE  = 1;
    localparam logic [PTR_BW:0]   FILL_FULL = (PTR_BW + 1)'(FRAME_LEN);
    localparam logic [PTR_BW:0]   FILL_LAST = (PTR_BW + 1)'(FRAME_LEN - 1);
    localparam logic [HOP_BW-1:0] HOP_ONE   = 1;
    localparam logic [HOP_BW-1:0] HOP_END   = HOP_BW'(HOP_LEN - 1);

    framer_state_t          state;
    logic [PTR_BW-1:0]      wr_ptr;
    logic [PTR_BW-1:0]      start_ptr;
    logic [PTR_BW-1:0]      rd_ptr;
    logic [PTR_BW-1:0]      rd_cnt;
    logic [PTR_BW:0]        fill_cnt;
    logic [HOP_BW-1:0]      hop_cnt;
    logic                   pending;
    logic                   valid_q;
    logic                   last_q;
    logic                   overrun_q;
    logic [SAMPLE_BW-1:0]   ram_q;

    logic                   clear;
    logic                   filled;
    logic                   trigger;
    logic                   launch;
    logic                   ram_re;
    logic [PTR_BW-1:0]      ram_rd_addr;

    assign clear   = rst_i || !bus.en_i;
    assign filled  = (fill_cnt == FILL_FULL);
    assign trigger = bus.valid_i && (filled ? (hop_cnt == HOP_END) : (fill_cnt == FILL_LAST));
    assign launch  = (state == WAIT) && bus.ready_i;

    // The first read is issued in the launch cycle so valid_o rises right after ready_i is seen.
    assign ram_re      = launch || (state == READ);
    assign ram_rd_addr = launch ? start_ptr : rd_ptr;

    fft_framer_ram #(
        .WIDTH (SAMPLE_BW),
        .DEPTH (FRAME_LEN)
    ) u_ram (
        .clk_i   (clk_i),
        .we      (bus.valid_i),
        .wr_addr (wr_ptr),
        .wr_data (bus.data_i),
        .re      (ram_re),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk_i) begin
        if (clear) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            start_ptr <= '0;
            rd_ptr    <= '0;
            rd_cnt    <= '0;
            fill_cnt  <= '0;
            hop_cnt   <= '0;
            pending   <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (bus.valid_i) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                if (!filled) begin
                    fill_cnt <= fill_cnt + FILL_ONE;
                end else begin
                    hop_cnt <= (hop_cnt == HOP_END) ? '0 : hop_cnt + HOP_ONE;
                end
            end

            if (launch) begin
                pending <= 1'b0;
            end

            // A trigger that finds a frame already queued is dropped; the queued start_ptr survives.
            if (trigger) begin
                if (pending) begin
                    overrun_q <= 1'b1;
                end else begin
                    pending   <= 1'b1;
                    start_ptr <= wr_ptr + PTR_ONE;
                end
            end

            case (state)
                IDLE: begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    if (pending) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.ready_i) begin
                        state   <= READ;
                        rd_ptr  <= start_ptr + PTR_ONE;
                        rd_cnt  <= PTR_ONE;
                        valid_q <= 1'b1;
                    end
                end
                READ: begin
                    rd_ptr  <= rd_ptr + PTR_ONE;
                    rd_cnt  <= rd_cnt + PTR_ONE;
                    valid_q <= 1'b1;
                    if (rd_cnt == RD_LAST) begin
                        last_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_o    = valid_q ? ram_q : '0;
    assign bus.valid_o   = valid_q;
    assign bus.last_o    = last_q;
    assign bus.overrun_o = overrun_q;

endmodule
